// File: rtl/t5_pkg.sv
// ----------------------------------------------------------------------------
// t5_pkg
// Shared definitions for the hart scheduler: per-hart state encoding,
// hart-id width and the hart count the interface is sized for.
// ----------------------------------------------------------------------------
package t5_pkg;

    // Hart count the interface widths are built for (2-bit hart ids).
    localparam int NHART_C = 4;
    localparam int HIDW    = 2;

    typedef logic [HIDW-1:0] hid_t;

    // Per-hart scheduling state. The encoding is visible on the hstate port.
    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_RUN   = 2'd1,
        HS_WAIT  = 2'd2,
        HS_SLEEP = 2'd3
    } hstate_t;

endpackage

// File: rtl/t5_hsched_if.sv
// ----------------------------------------------------------------------------
// t5_hsched_if
// Pipeline <-> scheduler signal bundle.
//   master : pipeline side, drives enable, hart events and stage hart ids
//   slave  : scheduler side, drives the fetch slot and per-hart state
// Signals:
//   sena          pipeline enable
//   hstart/hwake  per-hart start pulse / wake level
//   dwfi, dhart   decode-stage WFI and its hart
//   xmem, xhart   execute-stage load/store and its hart
//   xbra          execute {taken, exception}
//   mack, mhart   memory response and its hart
//   fvld, fhart   fetch slot valid / selected hart
//   fflush        kill younger instructions of fhart
//   hstate        2-bit state per hart, hart n at [2n+1:2n]
// ----------------------------------------------------------------------------
interface t5_hsched_if;
    import t5_pkg::*;

    logic                 sena;
    logic [NHART_C-1:0]   hstart;
    logic [NHART_C-1:0]   hwake;
    logic                 dwfi;
    hid_t                 dhart;
    logic                 xmem;
    hid_t                 xhart;
    logic [1:0]           xbra;
    logic                 mack;
    hid_t                 mhart;
    logic                 fvld;
    hid_t                 fhart;
    logic                 fflush;
    logic [2*NHART_C-1:0] hstate;

    modport master (
        output sena, hstart, hwake, dwfi, dhart, xmem, xhart, xbra, mack, mhart,
        input  fvld, fhart, fflush, hstate
    );

    modport slave (
        input  sena, hstart, hwake, dwfi, dhart, xmem, xhart, xbra, mack, mhart,
        output fvld, fhart, fflush, hstate
    );

endinterface

// File: rtl/t5_rrarb.sv
// ----------------------------------------------------------------------------
// t5_rrarb
// Combinational round-robin picker over NHART_C requesters.
//   req  in   request vector (one bit per hart)
//   ptr  in   last granted hart; search starts at ptr+1 and wraps 3->0
//   gnt  out  first requesting hart found
//   vld  out  at least one request present
// ----------------------------------------------------------------------------
module t5_rrarb
    import t5_pkg::*;
(
    input  logic [NHART_C-1:0] req,
    input  hid_t               ptr,
    output hid_t               gnt,
    output logic               vld
);

    // Walk from the farthest candidate back to ptr+1 so that the nearest
    // requester overwrites the others; offset NHART_C lands on ptr itself.
    always_comb begin
        gnt = ptr;
        vld = 1'b0;
        for (int i = NHART_C; i >= 1; i--) begin
            hid_t idx;
            idx = ptr + hid_t'(i);
            if (req[idx]) begin
                gnt = idx;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t5_hsched.sv
// ----------------------------------------------------------------------------
// t5_hsched
// Fine-grained multithread fetch scheduler: one FSM per hart plus a
// round-robin fetch picker with branch/exception flush override.
//   sclk  in  clock
//   srst  in  synchronous active-high reset
//   bus   slave side of t5_hsched_if (events in, fetch slot and states out)
// Parameters:
//   NHART    number of harts (4 in this release)
//   RSTHART  hart that is RUN out of reset
// ----------------------------------------------------------------------------
module t5_hsched
    import t5_pkg::*;
#(
    parameter int NHART   = 4,
    parameter int RSTHART = 0
) (
    input logic         sclk,
    input logic         srst,
    t5_hsched_if.slave  bus
);

    localparam hid_t RST_ID  = hid_t'(RSTHART);
    localparam hid_t RST_PTR = hid_t'(RSTHART - 1);

    logic [NHART-1:0]   runnxt;
    logic [2*NHART-1:0] hstate_w;
    hid_t               ptr;
    hid_t               gnt;
    logic               gvld;
    logic               fvld_q;
    hid_t               fhart_q;
    logic               fflush_q;
    logic               flush_req;

    for (genvar g = 0; g < NHART; g++) begin : g_hart
        localparam hstate_t RSTVAL = (g == RSTHART) ? HS_RUN : HS_IDLE;

        hstate_t cur;
        hstate_t nxt;
        logic    xmem_me;

        always_ff @(posedge sclk) begin
            if (srst) begin
                cur <= RSTVAL;
            end else begin
                cur <= nxt;
            end
        end

        assign xmem_me = bus.xmem && (bus.xhart == hid_t'(g));

        // A new memory request beats a same-cycle response; WFI is only
        // honoured from RUN, and a pending wake keeps the hart running.
        always_comb begin
            nxt = cur;
            if (bus.sena) begin
                case (cur)
                    HS_IDLE: begin
                        if (bus.hstart[g]) nxt = HS_RUN;
                    end
                    HS_RUN: begin
                        if (xmem_me)
                            nxt = HS_WAIT;
                        else if (bus.dwfi && (bus.dhart == hid_t'(g)) && !bus.hwake[g])
                            nxt = HS_SLEEP;
                    end
                    HS_WAIT: begin
                        if (bus.mack && (bus.mhart == hid_t'(g)) && !xmem_me)
                            nxt = HS_RUN;
                    end
                    HS_SLEEP: begin
                        if (bus.hwake[g]) nxt = HS_RUN;
                    end
                    default: nxt = cur;
                endcase
            end
        end

        // Eligibility looks at next state so a resumed hart fetches at once.
        assign runnxt[g]            = (nxt == HS_RUN);
        assign hstate_w[2*g+1:2*g]  = cur;
    end

    t5_rrarb u_arb (
        .req (runnxt),
        .ptr (ptr),
        .gnt (gnt),
        .vld (gvld)
    );

    assign flush_req = |bus.xbra;

    // Flush steals the slot for xhart and re-seeds the pointer from it;
    // fhart keeps its last value whenever no hart is eligible.
    always_ff @(posedge sclk) begin
        if (srst) begin
            fvld_q   <= 1'b0;
            fhart_q  <= RST_ID;
            fflush_q <= 1'b0;
            ptr      <= RST_PTR;
        end else if (bus.sena) begin
            if (flush_req) begin
                fflush_q <= 1'b1;
                fhart_q  <= bus.xhart;
                fvld_q   <= runnxt[bus.xhart];
                ptr      <= bus.xhart;
            end else begin
                fflush_q <= 1'b0;
                fvld_q   <= gvld;
                if (gvld) begin
                    fhart_q <= gnt;
                    ptr     <= gnt;
                end
            end
        end
    end

    assign bus.fvld   = fvld_q;
    assign bus.fhart  = fhart_q;
    assign bus.fflush = fflush_q;
    assign bus.hstate = hstate_w;

endmodule
